// File: rtl/prm_pkg.sv
// Shared definitions for the PRM edge-checking blocks: accumulator state
// encoding, default sizing and the obstacle code width.
package prm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } prm_state_t;

    localparam int PRM_NUM_EDGES  = 64;
    localparam int PRM_CNT_W      = 8;
    localparam int PRM_OBS_CODE_W = 15;

endpackage

// File: rtl/prm_popcount.sv
// Combinational population count of a WIDTH-bit vector.
module prm_popcount #(
    parameter int WIDTH = 64,
    localparam int CW   = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [CW-1:0]    cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < WIDTH; i++)
            cnt = cnt + CW'(vec[i]);
    end

endmodule

// File: rtl/prm_edge_mask_accum.sv
// ORs per-sample edge-blocked masks over an obstacle frame and hands the result
// off with valid/ready. Define PRM_EDGE_POPCNT_EN to build the free-edge count.
module prm_edge_mask_accum
    import prm_pkg::*;
#(
    parameter int NUM_EDGES = PRM_NUM_EDGES,
    parameter int CNT_W     = PRM_CNT_W,
    localparam int FC_W     = $clog2(NUM_EDGES + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_start,
    input  logic                 obs_valid,
    output logic                 obs_ready,
    input  logic                 obs_last,
    input  logic [NUM_EDGES-1:0] edge_mask_in,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [NUM_EDGES-1:0] blocked_mask,
    output logic [CNT_W-1:0]     obs_count,
    output logic                 sat,
    output logic [FC_W-1:0]      free_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    prm_state_t           state, state_nxt;
    logic                 accept;
    logic                 clr;
    logic                 vld_pipe;
    logic [NUM_EDGES-1:0] pipe_mask;

    assign obs_ready    = (state == ST_ACCUM);
    assign result_valid = (state == ST_DONE);
    assign accept       = obs_valid & obs_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // frame_start is honoured everywhere except a DONE result still waiting on its consumer
    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (frame_start) begin
                    state_nxt = ST_ACCUM;
                    clr       = 1'b1;
                end
            end
            ST_ACCUM: begin
                if (frame_start) begin
                    state_nxt = ST_ACCUM;
                    clr       = 1'b1;
                end else if (accept && obs_last) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (frame_start) begin
                    state_nxt = ST_ACCUM;
                    clr       = 1'b1;
                end else begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (result_ready) begin
                    state_nxt = frame_start ? ST_ACCUM : ST_IDLE;
                    clr       = frame_start;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            blocked_mask <= '0;
            obs_count    <= '0;
            sat          <= 1'b0;
            vld_pipe     <= 1'b0;
            pipe_mask    <= '0;
        end else begin
            if (vld_pipe)
                blocked_mask <= blocked_mask | pipe_mask;
            vld_pipe <= accept;
            if (accept) begin
                pipe_mask <= edge_mask_in;
                if (obs_count == CNT_MAX) sat       <= 1'b1;
                else                      obs_count <= obs_count + 1'b1;
            end
        end
    end

`ifdef PRM_EDGE_POPCNT_EN
    // Count the mask as it will look in DONE, i.e. with the pending stage merged.
    logic [NUM_EDGES-1:0] merged_mask;
    logic [FC_W-1:0]      ones;

    assign merged_mask = blocked_mask | ({NUM_EDGES{vld_pipe}} & pipe_mask);

    prm_popcount #(.WIDTH(NUM_EDGES)) u_popcount (
        .vec (merged_mask),
        .cnt (ones)
    );

    always_ff @(posedge clk) begin
        if (rst || clr)
            free_count <= '0;
        else if (state == ST_DRAIN)
            free_count <= FC_W'(NUM_EDGES) - ones;
    end
`else
    assign free_count = '0;
`endif

endmodule

// File: tb/tb_prm_edge_mask_accum.sv
// Scoreboard bench for prm_edge_mask_accum (NUM_EDGES=8, CNT_W=2).
module tb_prm_edge_mask_accum;

    localparam int NE = 8;
    localparam int CW = 2;
    localparam int FW = $clog2(NE + 1);

    logic          clk = 1'b0;
    logic          rst, frame_start, obs_valid, obs_last, result_ready;
    logic          obs_ready, result_valid, sat;
    logic [NE-1:0] edge_mask_in, blocked_mask;
    logic [CW-1:0] obs_count;
    logic [FW-1:0] free_count;

    always #5 clk = ~clk;

    prm_edge_mask_accum #(.NUM_EDGES(NE), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .obs_valid    (obs_valid),
        .obs_ready    (obs_ready),
        .obs_last     (obs_last),
        .edge_mask_in (edge_mask_in),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .blocked_mask (blocked_mask),
        .obs_count    (obs_count),
        .sat          (sat),
        .free_count   (free_count)
    );

    typedef struct {
        logic [NE-1:0] mask;
        logic [CW-1:0] cnt;
        logic          sat;
        logic [FW-1:0] fc;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    logic [NE-1:0] mdl_mask;
    logic [CW-1:0] mdl_cnt;
    logic          mdl_sat;

    function automatic logic [FW-1:0] fc_exp(input logic [NE-1:0] m);
`ifdef PRM_EDGE_POPCNT_EN
        return FW'(NE - $countones(m));
`else
        return '0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // All drive tasks are entered and left on a falling edge.
    task automatic start();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        mdl_mask = '0; mdl_cnt = '0; mdl_sat = 1'b0;
    endtask

    task automatic send(input logic [NE-1:0] m, input logic last);
        exp_t e;
        chk("obs_ready", obs_ready, 1);
        obs_valid = 1'b1; edge_mask_in = m; obs_last = last;
        @(negedge clk);
        obs_valid = 1'b0; edge_mask_in = '0; obs_last = 1'b0;
        mdl_mask = mdl_mask | m;
        if (mdl_cnt == '1) mdl_sat = 1'b1;
        else               mdl_cnt = mdl_cnt + 1'b1;
        if (last) begin
            e.mask = mdl_mask; e.cnt = mdl_cnt; e.sat = mdl_sat; e.fc = fc_exp(mdl_mask);
            sb.push_back(e);
        end
    endtask

    task automatic wait_result();
        int   n;
        exp_t e;
        chk("drain_rv", result_valid, 0);
        n = 0;
        while (!result_valid && n < 4) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, 1);
        chk("sb_size", sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("mask",  blocked_mask, e.mask);
            chk("count", obs_count,    e.cnt);
            chk("sat",   sat,          e.sat);
            chk("free",  free_count,   e.fc);
        end
    endtask

    task automatic release_result();
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        chk("rel_rv", result_valid, 0);
        chk("rel_rdy", obs_ready, 0);
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; obs_valid = 1'b0; obs_last = 1'b0;
        edge_mask_in = '0; result_ready = 1'b0;
        mdl_mask = '0; mdl_cnt = '0; mdl_sat = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rdy",  obs_ready, 0);
        chk("rst_rv",   result_valid, 0);
        chk("rst_mask", blocked_mask, 0);
        chk("rst_cnt",  obs_count, 0);
        chk("rst_sat",  sat, 0);
        chk("rst_free", free_count, 0);
        rst = 1'b0;

        // Basic frame, then a stalled consumer with stray obs_valid in DONE
        start();
        send(8'h01, 0); send(8'h10, 0); send(8'h01, 1);
        wait_result();
        for (int i = 0; i < 5; i++) begin
            obs_valid = 1'b1; edge_mask_in = 8'hFF;
            @(negedge clk);
            obs_valid = 1'b0; edge_mask_in = '0;
            chk("hold_rv",   result_valid, 1);
            chk("hold_rdy",  obs_ready, 0);
            chk("hold_mask", blocked_mask, 8'h11);
            chk("hold_cnt",  obs_count, 3);
            chk("hold_free", free_count, fc_exp(8'h11));
        end
        release_result();
        for (int i = 0; i < 2; i++) begin
            obs_valid = 1'b1; obs_last = 1'b1; edge_mask_in = 8'hFF;
            @(negedge clk);
            obs_valid = 1'b0; obs_last = 1'b0; edge_mask_in = '0;
            chk("idle_mask", blocked_mask, 8'h11);
            chk("idle_cnt",  obs_count, 3);
            chk("idle_rv",   result_valid, 0);
        end

        // Counter saturation
        start();
        for (int i = 0; i < 5; i++) send(8'h00, 0);
        send(8'h80, 1);
        wait_result();
        release_result();

        // Abort mid-frame with a pending pipeline stage
        start();
        send(8'hFF, 0); send(8'hFF, 0);
        start();
        send(8'h02, 1);
        wait_result();

        // frame_start in DONE without result_ready is ignored
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        chk("fs_done_rv",   result_valid, 1);
        chk("fs_done_mask", blocked_mask, 8'h02);

        // frame_start with result_ready in DONE restarts cleared
        frame_start = 1'b1; result_ready = 1'b1;
        @(negedge clk);
        frame_start = 1'b0; result_ready = 1'b0;
        mdl_mask = '0; mdl_cnt = '0; mdl_sat = 1'b0;
        chk("hs_rdy",  obs_ready, 1);
        chk("hs_rv",   result_valid, 0);
        chk("hs_mask", blocked_mask, 0);
        chk("hs_cnt",  obs_count, 0);

        // frame_start beats an obs_last accept
        send(8'h40, 0);
        sb.delete();
        frame_start = 1'b1; obs_valid = 1'b1; obs_last = 1'b1; edge_mask_in = 8'h01;
        @(negedge clk);
        frame_start = 1'b0; obs_valid = 1'b0; obs_last = 1'b0; edge_mask_in = '0;
        mdl_mask = '0; mdl_cnt = '0; mdl_sat = 1'b0;
        chk("prio_rdy", obs_ready, 1);
        chk("prio_cnt", obs_count, 0);
        @(negedge clk);
        chk("prio_rv",   result_valid, 0);
        chk("prio_mask", blocked_mask, 0);
        send(8'h03, 1);
        wait_result();
        release_result();

        // Reset while in DRAIN
        start();
        send(8'h04, 0); send(8'h08, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        chk("drst_rdy",  obs_ready, 0);
        chk("drst_rv",   result_valid, 0);
        chk("drst_mask", blocked_mask, 0);
        chk("drst_cnt",  obs_count, 0);
        chk("drst_sat",  sat, 0);
        chk("drst_free", free_count, 0);
        @(negedge clk);
        chk("drst_idle_rv", result_valid, 0);

        start();
        send(8'h20, 1);
        wait_result();
        release_result();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
